// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, funct
// codes, controller state encoding, mux-select encodings and ALU codes.
package mips_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Controller states, 4-bit binary encoding
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Main-decoder to ALU-decoder operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // True for the opcodes this controller knows how to sequence
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the operation class and R-type funct to an ALU code.
module aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  // Select the ALU operation; unknown funct values fall back to AND
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU and unified memory,
// stalls on mem_ready and counts retired instructions.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alu_control,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state;
  state_t     next_state;
  logic       pcwrite;
  logic       branch;
  logic       irwrite_raw;
  logic       memwrite_raw;
  logic       regwrite_raw;
  logic       illegal_raw;
  logic       done_raw;
  logic [1:0] alu_op;

  // State register; reset lands in FETCH at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, including the memory-ready stalls
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: begin
        if (mem_ready) next_state = S_DECODE;
        else           next_state = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      next_state = S_MEMRD;
        else if (op == OP_SW) next_state = S_MEMWR;
        else                  next_state = S_FETCH;
      end
      S_MEMRD: begin
        if (mem_ready) next_state = S_MEMWB;
        else           next_state = S_MEMRD;
      end
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) next_state = S_FETCH;
        else           next_state = S_MEMWR;
      end
      S_EXECUTE: next_state = S_ALUWB;
      S_ALUWB:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_ADDIWB:  next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      default:   next_state = S_FETCH;
    endcase
  end

  // Moore output decode; mem_ready only gates strobes in memory states
  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REG;
    pcsrc        = PCSRC_ALU;
    alu_op       = ALUOP_ADD;
    illegal_raw  = 1'b0;
    done_raw     = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb = SRCB_FOUR;
        if (mem_ready) begin
          irwrite_raw = 1'b1;
          pcwrite     = 1'b1;
        end else begin
          irwrite_raw = 1'b0;
          pcwrite     = 1'b0;
        end
      end
      S_DECODE: begin
        // Branch target PC + (imm << 2) is precomputed into ALUOut here
        alusrcb     = SRCB_IMM_SH2;
        illegal_raw = ~op_supported(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_MEMWR: begin
        // The write strobe is held until the memory accepts it
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (mem_ready) done_raw = 1'b1;
        else           done_raw = 1'b0;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        alusrcb = SRCB_REG;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        alu_op   = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        branch   = 1'b1;
        done_raw = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_JUMP: begin
        pcsrc    = PCSRC_JUMP;
        pcwrite  = 1'b1;
        done_raw = 1'b1;
      end
      default: begin
        alusrcb = SRCB_FOUR;
      end
    endcase
  end

  // Strobes are suppressed while reset is held so nothing fires mid-abort
  assign pc_en      = rst_n & (pcwrite | (branch & zero));
  assign irwrite    = rst_n & irwrite_raw;
  assign memwrite   = rst_n & memwrite_raw;
  assign regwrite   = rst_n & regwrite_raw;
  assign illegal_op = rst_n & illegal_raw;
  assign instr_done = rst_n & done_raw;

  aludec u_aludec (
    .funct       (funct),
    .alu_op      (alu_op),
    .alu_control (alu_control)
  );

  // Retired-instruction counter, advancing on each final-state edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= {CNT_W{1'b0}};
    end else if (done_raw) begin
      instr_count <= instr_count + CNT_W'(1);
    end else begin
      instr_count <= instr_count;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into an expected per-cycle output trace built from the instruction rules.
module tb_multicycle_controller;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic          zero;
  logic          mem_ready;
  logic          pc_en, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0]    alusrcb, pcsrc;
  logic [2:0]    alu_control;
  logic          illegal_op, instr_done;
  logic [CW-1:0] instr_count;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .irwrite(irwrite),
    .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alu_control(alu_control), .illegal_op(illegal_op),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        mr;
    logic        z;
    logic [16:0] vec;
    logic        done;
  } step_t;

  step_t         q[$];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] cnt = '0;
  logic          prev_done = 1'b0;
  logic [16:0]   exp_vec;
  logic [16:0]   reset_vec;

  // Output vector: pc_en iord irwrite memwrite regwrite regdst memtoreg
  // alusrca alusrcb[2] pcsrc[2] alu_control[3] illegal_op instr_done
  function automatic logic [16:0] ev(input logic pe, input logic io, input logic irw,
      input logic mw, input logic rw, input logic rd, input logic m2r, input logic sa,
      input logic [1:0] sb, input logic [1:0] ps, input logic [2:0] ctl,
      input logic ill, input logic dn);
    return {pe, io, irw, mw, rw, rd, m2r, sa, sb, ps, ctl, ill, dn};
  endfunction

  function automatic logic [16:0] got_vec();
    return {pc_en, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
            alusrcb, pcsrc, alu_control, illegal_op, instr_done};
  endfunction

  function automatic logic [2:0] funct_ctl(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic legal(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic [5:0] o, input logic [5:0] f, input logic mr,
                      input logic z, input logic [16:0] v, input logic dn);
    step_t s;
    s.op = o; s.funct = f; s.mr = mr; s.z = z; s.vec = v; s.done = dn;
    q.push_back(s);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected cycle-by-cycle trace
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int fst, input int mst);
    for (int i = 0; i < fst; i++)
      push(o, f, 1'b0, rb(), ev(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0), 1'b0);
    push(o, f, 1'b1, rb(), ev(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0,0), 1'b0);
    push(o, f, rb(), rb(), ev(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,!legal(o),0), 1'b0);
    if (!legal(o)) return;
    case (o)
      6'b100011: begin
        push(o, f, rb(), rb(), ev(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0), 1'b0);
        for (int i = 0; i < mst; i++)
          push(o, f, 1'b0, rb(), ev(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0), 1'b0);
        push(o, f, 1'b1, rb(), ev(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0), 1'b0);
        push(o, f, rb(), rb(), ev(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,0,1), 1'b1);
      end
      6'b101011: begin
        push(o, f, rb(), rb(), ev(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0), 1'b0);
        for (int i = 0; i < mst; i++)
          push(o, f, 1'b0, rb(), ev(0,1,0,1,0,0,0,0,2'b00,2'b00,3'b010,0,0), 1'b0);
        push(o, f, 1'b1, rb(), ev(0,1,0,1,0,0,0,0,2'b00,2'b00,3'b010,0,1), 1'b1);
      end
      6'b000000: begin
        push(o, f, rb(), rb(), ev(0,0,0,0,0,0,0,1,2'b00,2'b00,funct_ctl(f),0,0), 1'b0);
        push(o, f, rb(), rb(), ev(0,0,0,0,1,1,0,0,2'b00,2'b00,3'b010,0,1), 1'b1);
      end
      6'b000100:
        push(o, f, rb(), z, ev(z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,1), 1'b1);
      6'b001000: begin
        push(o, f, rb(), rb(), ev(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0), 1'b0);
        push(o, f, rb(), rb(), ev(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0,1), 1'b1);
      end
      default:
        push(o, f, rb(), rb(), ev(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0,1), 1'b1);
    endcase
  endtask

  // Per-cycle comparison of every output and the retired count
  task automatic compare_cycle();
    checks++;
    if (got_vec() !== exp_vec) begin
      failures++;
      $display("FAIL outputs op=%b: got %b expected %b at %0t", op, got_vec(), exp_vec, $time);
    end
    check("instr_count", 32'(instr_count), 32'(cnt));
  endtask

  // Apply one trace step just after the edge and check it before the next one
  task automatic step(input step_t s);
    @(posedge clk);
    if (prev_done) cnt = cnt + 1'b1;
    prev_done = 1'b0;
    #1;
    op = s.op; funct = s.funct; mem_ready = s.mr; zero = s.z;
    exp_vec = s.vec;
    @(negedge clk);
    compare_cycle();
    prev_done = s.done;
  endtask

  task automatic run_q();
    while (q.size() > 0) step(q.pop_front());
  endtask

  // Idle one cycle in FETCH with memory not ready, folding in the last retirement
  task automatic settle();
    @(posedge clk);
    if (prev_done) cnt = cnt + 1'b1;
    prev_done = 1'b0;
    #1;
    mem_ready = 1'b0;
  endtask

  initial begin
    reset_vec = ev(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
    rst_n = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b1; mem_ready = 1'b1;
    #12;
    check("reset_outputs", 32'(got_vec()), 32'(reset_vec));
    check("reset_count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;

    // add: 4 cycles, one retirement
    build(6'b000000, 6'b100000, 1'b0, 0, 0);
    check("add_trace_len", 32'(q.size()), 32'd4);
    check("add_wb_regdst", 32'(q[3].vec[11]), 32'd1);
    run_q(); settle();
    check("add_count", 32'(instr_count), 32'd1);

    // lw with two stall cycles in MEMRD: 7 cycles
    build(6'b100011, 6'h00, 1'b0, 0, 2);
    check("lw_stall_len", 32'(q.size()), 32'd7);
    run_q(); settle();
    check("lw_count", 32'(instr_count), 32'd2);

    // sw with one stall cycle: memwrite over 2 cycles
    build(6'b101011, 6'h00, 1'b0, 0, 1);
    check("sw_stall_len", 32'(q.size()), 32'd5);
    run_q(); settle();

    // beq taken and not taken
    build(6'b000100, 6'h00, 1'b1, 0, 0);
    check("beq_taken_pcen", 32'(q[2].vec[16]), 32'd1);
    run_q();
    build(6'b000100, 6'h00, 1'b0, 0, 0);
    run_q(); settle();
    check("beq_count", 32'(instr_count), 32'd5);

    // illegal op: 2 cycles, not counted; then j
    build(6'b111111, 6'h00, 1'b0, 0, 0);
    check("illegal_len", 32'(q.size()), 32'd2);
    run_q(); settle();
    check("illegal_count", 32'(instr_count), 32'd5);
    build(6'b000010, 6'h00, 1'b0, 1, 0);
    run_q(); settle();
    check("j_count", 32'(instr_count), 32'd6);

    // randomized instruction mix with random stalls
    for (int n = 0; n < 80; n++) begin
      logic [5:0] o;
      logic [5:0] f;
      int k;
      k = $urandom_range(0, 6);
      case (k)
        0: o = 6'b000000;
        1: o = 6'b100011;
        2: o = 6'b101011;
        3: o = 6'b000100;
        4: o = 6'b001000;
        5: o = 6'b000010;
        default: o = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 5))
        0: f = 6'b100000;
        1: f = 6'b100010;
        2: f = 6'b100100;
        3: f = 6'b100101;
        4: f = 6'b101010;
        default: f = 6'($urandom_range(0, 63));
      endcase
      build(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
      run_q();
    end
    settle();

    // reset asserted while lw waits in MEMRD
    build(6'b100011, 6'h00, 1'b0, 0, 3);
    for (int i = 0; i < 4; i++) step(q.pop_front());
    q.delete();
    #2;
    rst_n = 1'b0; mem_ready = 1'b1;
    cnt = '0; prev_done = 1'b0;
    #1;
    check("midreset_outputs", 32'(got_vec()), 32'(reset_vec));
    check("midreset_count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    check("held_reset_outputs", 32'(got_vec()), 32'(reset_vec));
    mem_ready = 1'b0;
    rst_n = 1'b1;

    // counter wraps modulo 2^CW
    for (int i = 0; i < 15; i++) begin
      build(6'b000010, 6'h00, 1'b0, 0, 0);
      run_q();
    end
    settle();
    check("count_15", 32'(instr_count), 32'd15);
    build(6'b000010, 6'h00, 1'b0, 0, 0);
    run_q(); settle();
    check("count_wrap", 32'(instr_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the MIPS core. It replaces the single-cycle combinational decode with a Moore state machine that sequences one shared ALU and one unified instruction/data memory over several cycles per instruction. It also stalls on a memory ready handshake and counts retired instructions. It sits beside the multi-cycle datapath: it drives every mux select and write strobe there, and it consumes the opcode/funct fields from the instruction register plus the ALU zero flag.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous reset, active low.
- op  in  6  instruction register [31:26].
- funct  in  6  instruction register [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_en  out  1  PC load enable: pcwrite | (branch & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  instruction register load.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write.
- regdst  out  1  write register select: 1 = rd, 0 = rt.
- memtoreg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- instr_count  out  CNT_W  number of retired instructions.

## Operation
- Supported ops: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Outputs are Moore: decoded from the state, with mem_ready gating the strobes in memory states.
- Unlisted outputs are 0. alu_op defaults to 00.
- FETCH: alusrcb = 01, alu_op = 00.
  - If mem_ready: irwrite = 1, pcwrite = 1, go to DECODE.
  - Else hold FETCH with both strobes at 0.
- DECODE: alusrcb = 11, alu_op = 00 (branch target into ALUOut).
  - Next state by op: lw/sw → MEMADR, R → EXECUTE, beq → BRANCH, addi → ADDIEX, j → JUMP.
  - Any other op → FETCH, with illegal_op = 1 for this cycle.
- MEMADR: alusrca = 1, alusrcb = 10. lw → MEMRD, sw → MEMWR.
- MEMRD: iord = 1. Hold until mem_ready, then go to MEMWB.
- MEMWB: memtoreg = 1, regwrite = 1, regdst = 0. Final state.
- MEMWR: iord = 1, memwrite = 1. memwrite stays asserted until mem_ready; then FETCH. Final state when mem_ready.
- EXECUTE: alusrca = 1, alusrcb = 00, alu_op = 10.
- ALUWB: regdst = 1, regwrite = 1. Final state.
- BRANCH: alusrca = 1, alu_op = 01, pcsrc = 01, branch = 1. Final state.
- ADDIEX: alusrca = 1, alusrcb = 10.
- ADDIWB: regwrite = 1. Final state.
- JUMP: pcsrc = 10, pcwrite = 1. Final state.
- Every final state returns to FETCH.
- alu_control mapping:
  - alu_op 00 → 010; alu_op 01 → 110.
  - alu_op 10 → by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, other → 000.
- instr_done is asserted in each final state; instr_count increments on that edge and wraps modulo 2^CNT_W.
- Illegal ops are not counted as retired.

## Timing
- Reset (rst_n = 0): state = FETCH and instr_count = 0, both immediately.
  - All strobes forced to 0: pc_en, irwrite, memwrite, regwrite, illegal_op, instr_done.
  - Selects take their FETCH values: alusrcb = 01, alu_control = 010, all others 0.
- Reset asserted mid-instruction aborts it: no strobe fires and the count is unchanged. The first fetch starts on the first rising edge after rst_n goes high.
- Cycles per instruction with mem_ready tied high: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- beq: pc_en = zero in the BRANCH cycle.
- Pulse timing:
  - illegal_op lasts exactly one cycle.
  - Illegal-op recovery: DECODE → FETCH, 2 cycles total.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct localparams;
  - state enum, 4-bit binary encoding;
  - alusrcb/pcsrc encodings;
  - alu_control codes.
- Sub-module: reuse the existing `aludec` unchanged for alu_op/funct → alu_control. The FSM, output decode and counter live in `multicycle_controller`.

## Test plan
- Reset, then add (op 000000, funct 100000), mem_ready = 1 → states FETCH, DECODE, EXECUTE, ALUWB; regwrite = 1 and regdst = 1 in cycle 4; instr_count = 1.
- lw with mem_ready low for 2 cycles in MEMRD → 7 cycles total; iord = 1 held through the stall; regwrite only in MEMWB.
- sw with mem_ready low for 1 cycle → memwrite high for 2 consecutive cycles, then FETCH; regwrite is never asserted.
- beq with zero = 1 → pc_en = 1 and pcsrc = 01 in cycle 3. Repeat with zero = 0 → pc_en = 0 in cycle 3.
- op 111111 → illegal_op pulses in DECODE and FETCH follows; instr_count is unchanged. Then j → pcsrc = 10 and pc_en = 1 in cycle 3.
- Assert rst_n = 0 during lw in MEMRD → state = FETCH immediately, strobes 0, instr_count = 0. Run 2^CNT_W retirements with CNT_W overridden to 4 → count wraps 15 → 0.
